// File: rtl/bcd_seconds_counter.sv
// Seconds timebase and BCD seconds counter (00-59).
// A prescaler divides clk_i down to one second event per CLK_DIV cycles. Each
// event, or a manual inc_i pulse, advances the two BCD digits. tick_o and
// carry_o are registered pulses that are high in the cycle the new digits show.
module bcd_seconds_counter #(
  parameter int unsigned CLK_DIV = 50_000_000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       run_i,
  input  logic       clear_i,
  input  logic       load_i,
  input  logic [3:0] load_ones_i,
  input  logic [2:0] load_tens_i,
  input  logic       inc_i,
  output logic [3:0] bcd_ones_o,
  output logic [2:0] bcd_tens_o,
  output logic       blink_o,
  output logic       tick_o,
  output logic       carry_o
);

  localparam int unsigned CntW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLK_DIV / 2);

  logic [CntW-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]      ones_q, ones_d;
  logic [2:0]      tens_q, tens_d;
  logic            blink_q, blink_d;
  logic            tick_q, tick_d;
  logic            carry_q, carry_d;
  logic            sec_evt;
  logic            advance;

  // Prescaler only reaches its terminal count while running, so a paused
  // counter never fires an event.
  assign sec_evt = run_i && (div_cnt_q == CntMax);
  assign advance = sec_evt || inc_i;

  // Next-state: clear beats load beats advance; tick/carry default low.
  always_comb begin
    div_cnt_d = div_cnt_q;
    ones_d    = ones_q;
    tens_d    = tens_q;
    tick_d    = 1'b0;
    carry_d   = 1'b0;
    blink_d   = run_i ? (div_cnt_q < CntHalf) : 1'b1;

    // inc_i alone leaves the prescaler phase untouched.
    if (run_i) begin
      div_cnt_d = sec_evt ? '0 : div_cnt_q + 1'b1;
    end

    if (clear_i) begin
      div_cnt_d = '0;
      ones_d    = '0;
      tens_d    = '0;
    end else if (load_i) begin
      div_cnt_d = '0;
      // Each digit is range-checked on its own; illegal BCD loads as zero.
      ones_d    = (load_ones_i > 4'd9) ? 4'd0 : load_ones_i;
      tens_d    = (load_tens_i > 3'd5) ? 3'd0 : load_tens_i;
    end else if (advance) begin
      tick_d = 1'b1;
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        if (tens_q == 3'd5) begin
          tens_d  = 3'd0;
          carry_d = 1'b1;
        end else begin
          tens_d = tens_q + 3'd1;
        end
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  // State and registered outputs, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt_q <= '0;
      ones_q    <= '0;
      tens_q    <= '0;
      blink_q   <= 1'b0;
      tick_q    <= 1'b0;
      carry_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      ones_q    <= ones_d;
      tens_q    <= tens_d;
      blink_q   <= blink_d;
      tick_q    <= tick_d;
      carry_q   <= carry_d;
    end
  end

  assign bcd_ones_o = ones_q;
  assign bcd_tens_o = tens_q;
  assign blink_o    = blink_q;
  assign tick_o     = tick_q;
  assign carry_o    = carry_q;

endmodule

// File: tb/tb_bcd_seconds_counter.sv
// Bench for bcd_seconds_counter with CLK_DIV=4. The driver applies inputs on
// the falling edge, advances an integer-seconds reference model and queues the
// expected outputs; the monitor pops one entry per rising edge and compares.
module tb_bcd_seconds_counter;

  localparam int unsigned ClkDiv = 4;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       run_i = 1'b0;
  logic       clear_i = 1'b0;
  logic       load_i = 1'b0;
  logic [3:0] load_ones_i = '0;
  logic [2:0] load_tens_i = '0;
  logic       inc_i = 1'b0;
  logic [3:0] bcd_ones_o;
  logic [2:0] bcd_tens_o;
  logic       blink_o;
  logic       tick_o;
  logic       carry_o;

  bcd_seconds_counter #(.CLK_DIV(ClkDiv)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .run_i       (run_i),
    .clear_i     (clear_i),
    .load_i      (load_i),
    .load_ones_i (load_ones_i),
    .load_tens_i (load_tens_i),
    .inc_i       (inc_i),
    .bcd_ones_o  (bcd_ones_o),
    .bcd_tens_o  (bcd_tens_o),
    .blink_o     (blink_o),
    .tick_o      (tick_o),
    .carry_o     (carry_o)
  );

  always #5 clk_i = ~clk_i;

  // Packed as {ones, tens, tick, carry, blink}.
  logic [9:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int carries_seen = 0;

  // Reference model: elapsed seconds within the minute and prescale phase.
  int secs = 0;
  int phase = 0;

  function automatic logic [9:0] pack(int s, logic tk, logic cy, logic bl);
    logic [3:0] o;
    logic [2:0] t;
    o = 4'(s % 10);
    t = 3'(s / 10);
    return {o, t, tk, cy, bl};
  endfunction

  function automatic logic [9:0] dut_out();
    return {bcd_ones_o, bcd_tens_o, tick_o, carry_o, blink_o};
  endfunction

  task automatic step(input logic run, input logic clr, input logic ld, input int lo,
                      input int lt, input logic inc);
    logic tk, cy, bl, evt;
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_i = run; clear_i = clr; load_i = ld; inc_i = inc;
    load_ones_i = 4'(lo); load_tens_i = 3'(lt);
    tk = 1'b0; cy = 1'b0;
    bl = run ? (phase < int'(ClkDiv / 2)) : 1'b1;
    evt = run && (phase == int'(ClkDiv) - 1);
    if (clr) begin
      secs = 0; phase = 0;
    end else if (ld) begin
      secs = ((lt > 5) ? 0 : lt) * 10 + ((lo > 9) ? 0 : lo);
      phase = 0;
    end else begin
      if (run) phase = evt ? 0 : phase + 1;
      if (evt || inc) begin
        tk = 1'b1;
        cy = (secs == 59);
        secs = (secs + 1) % 60;
      end
    end
    exp_q.push_back(pack(secs, tk, cy, bl));
  endtask

  // Async reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (dut_out() !== 10'd0) begin
      failures++;
      $display("FAIL async_reset: got %b want %b", dut_out(), 10'd0);
    end
    secs = 0; phase = 0;
    exp_q.push_back(10'd0);
  endtask

  task automatic idle(input int n, input logic run);
    for (int i = 0; i < n; i++) step(run, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  // Monitor: every rising edge with a pending expectation is compared.
  initial begin
    logic [9:0] e;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (carry_o) carries_seen++;
        if (dut_out() !== e) begin
          failures++;
          $display("FAIL outputs t=%0t: got ones=%0d tens=%0d tick=%b carry=%b blink=%b want ones=%0d tens=%0d tick=%b carry=%b blink=%b",
                   $time, bcd_ones_o, bcd_tens_o, tick_o, carry_o, blink_o,
                   e[9:6], e[5:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    int c0;
    do_reset();
    // Free run through a full minute and past the wrap.
    idle(50, 1'b1);
    c0 = carries_seen;
    idle(240, 1'b1);
    repeat (2) @(posedge clk_i);
    #2;
    checks++;
    if (carries_seen - c0 != 1) begin
      failures++;
      $display("FAIL carry_count: got %0d want 1", carries_seen - c0);
    end
    // Load 59 and manually increment while paused.
    step(1'b0, 1'b0, 1'b1, 9, 5, 1'b0);
    step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    idle(3, 1'b0);
    // Out-of-range loads.
    step(1'b0, 1'b0, 1'b1, 12, 7, 1'b0);
    step(1'b0, 1'b0, 1'b1, 3, 7, 1'b0);
    step(1'b0, 1'b0, 1'b1, 15, 4, 1'b0);
    // Priority: clear with load and inc at 42.
    step(1'b1, 1'b0, 1'b1, 2, 4, 1'b0);
    step(1'b1, 1'b1, 1'b1, 5, 3, 1'b1);
    step(1'b1, 1'b0, 1'b1, 7, 2, 1'b1);
    // Steady run, then pause at phase 2 for 10 cycles and resume.
    idle(9, 1'b1);
    while (phase != 2) step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    idle(10, 1'b0);
    idle(6, 1'b1);
    // inc coinciding with the internal event counts once.
    while (phase != int'(ClkDiv) - 1) step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
    // Reset mid-period at 37 with the prescaler part-way through.
    step(1'b1, 1'b0, 1'b1, 7, 3, 1'b0);
    idle(2, 1'b1);
    do_reset();
    idle(6, 1'b1);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic r, c, l, n;
      r = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 63) == 0);
      l = ($urandom_range(0, 31) == 0);
      n = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      else step(r, c, l, int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), n);
    end
    step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk_i);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
